// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready front end for a combinational 16-bit ALU that iterates single-bit shifts.
// Optional ALU_STICKY_OVF_EN adds ovf_clr/ovf_sticky, a sticky record of responses that reported overflow.
module alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ALU_STICKY_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf_sticky,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [CNT_W-1:0]  req_count,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_op,
    input  logic [DATA_W-1:0] alu_q,
    input  logic [4:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_q,
    output logic [4:0]        rsp_flags,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
    localparam logic [4:0] OP_XOR = 5'b11100, OP_QUIET = 5'b10000;
    logic [1:0]        state_q, state_d;
    logic [4:0]        op_q, op_d, flags_q, flags_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_shift, op_shift, zero_cnt, exec;
    assign req_shift = req_op[4] & req_op[3] & (req_op != OP_XOR);
    assign op_shift  = op_q[4] & op_q[3] & (op_q != OP_XOR);
    assign zero_cnt  = req_shift && req_count == '0;
    assign exec      = state_q == EXEC;
    assign req_ready = (state_q == IDLE) & ~reset;
    assign rsp_valid = state_q == RESP;
    assign busy      = state_q != IDLE;
    assign rsp_q     = res_q;
    assign rsp_flags = flags_q;
    assign alu_a     = exec ? a_q : '0;
    assign alu_b     = exec ? b_q : '0;
    assign alu_op    = exec ? op_q : OP_QUIET;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flags_d = flags_q;
        if (state_q == IDLE) begin
            if (req_valid) begin
                op_d    = req_op;
                a_d     = req_a;
                b_d     = req_b;
                cnt_d   = req_count;
                state_d = zero_cnt ? RESP : EXEC;
                res_d   = zero_cnt ? req_b : res_q;
                flags_d = zero_cnt ? {4'b0, req_b == '0} : flags_q;
            end
        end else if (exec) begin
            // each step overwrites the result, so only the final evaluation's flags survive
            res_d   = alu_q;
            flags_d = alu_flags;
            b_d     = op_shift ? alu_q : b_q;
            cnt_d   = op_shift ? cnt_q - CNT_W'(1) : cnt_q;
            state_d = (!op_shift || cnt_q == CNT_W'(1)) ? RESP : EXEC;
        end else begin
            state_d = (state_q == RESP && !rsp_ready) ? RESP : IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end
`ifdef ALU_STICKY_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf_d      = (ovf_q & ~ovf_clr) | (rsp_valid & rsp_ready & flags_q[4]);
    assign ovf_sticky = ovf_q;
    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end
`endif
endmodule
